// File: rtl/i3c_fmt_sequencer.sv
// I3C format sequencer: turns a command plus write-byte stream into
// host fmt_fifo entries, then waits for bus idle and reports status.
module i3c_fmt_sequencer #(
  parameter logic [15:0] IdleTimeoutCycles = 16'hFFFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [6:0] cmd_addr_i,
  input  logic       cmd_rnw_i,
  input  logic [7:0] cmd_len_i,
  input  logic       txd_valid_i,
  output logic       txd_ready_o,
  input  logic [7:0] txd_data_i,
  output logic       fmt_valid_o,
  input  logic       fmt_ready_i,
  output logic [7:0] fmt_byte_o,
  output logic       fmt_start_o,
  output logic       fmt_stop_o,
  output logic       fmt_readb_o,
  output logic       fmt_rcont_o,
  output logic       fmt_nakok_o,
  input  logic       host_idle_i,
  input  logic       event_nak_i,
  output logic       nak_pending_o,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [1:0] rsp_status_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WR,
    S_RD,
    S_DRAIN,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [1:0] StOk      = 2'b00;
  localparam logic [1:0] StNak     = 2'b01;
  localparam logic [1:0] StTimeout = 2'b10;
  localparam logic [1:0] StIllegal = 2'b11;

  // Timeout fires in the cycle whose counter completes the budget.
  localparam logic [15:0] TmoLast = IdleTimeoutCycles - 16'd1;

  state_t      state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic        rnw_q, rnw_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] cnt_q, cnt_d;
  logic        nak_q, nak_d;
  logic [1:0]  status_q, status_d;

  logic        nak_hit;
  logic        nak_now;
  logic        xfer;
  logic [7:0]  rem_nx;
  logic        cmd_ready_c;
  logic        txd_ready_c;
  logic        rsp_valid_c;
  logic        fv;
  logic [7:0]  fb;
  logic        fs;
  logic        fp;
  logic        frb;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rnw_d       = rnw_q;
    len_d       = len_q;
    rem_d       = rem_q;
    cnt_d       = 16'd0;
    status_d    = status_q;
    cmd_ready_c = 1'b0;
    txd_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    fv          = 1'b0;
    fb          = 8'h00;
    fs          = 1'b0;
    fp          = 1'b0;
    frb         = 1'b0;
    xfer        = 1'b0;
    rem_nx      = rem_q;
    nak_hit     = event_nak_i &&
                  (state_q == S_ADDR || state_q == S_WR ||
                   state_q == S_RD   || state_q == S_WAIT);
    nak_now     = nak_q | nak_hit;
    nak_d       = nak_now;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_c = 1'b1;
        if (cmd_valid_i) begin
          addr_d = cmd_addr_i;
          rnw_d  = cmd_rnw_i;
          len_d  = cmd_len_i;
          rem_d  = cmd_len_i;
          if (cmd_len_i == 8'd0) begin
            status_d = StIllegal;
            state_d  = S_RESP;
          end else begin
            state_d  = S_ADDR;
          end
        end
      end

      S_ADDR: begin
        fv = !nak_q;
        fb = {addr_q, rnw_q};
        fs = 1'b1;
        // A NAKed write still has its whole payload queued upstream.
        if (nak_hit) begin
          state_d = rnw_q ? S_WAIT : S_DRAIN;
        end else if (fv && fmt_ready_i) begin
          state_d = rnw_q ? S_RD : S_WR;
        end
      end

      S_WR: begin
        fv          = txd_valid_i && !nak_q;
        fb          = txd_data_i;
        fp          = (rem_q == 8'd1);
        txd_ready_c = fmt_ready_i && !nak_q;
        xfer        = fv && fmt_ready_i;
        rem_nx      = rem_q - {7'd0, xfer};
        rem_d       = rem_nx;
        if (nak_hit) begin
          state_d = (rem_nx != 8'd0) ? S_DRAIN : S_WAIT;
        end else if (xfer && rem_q == 8'd1) begin
          state_d = S_WAIT;
        end
      end

      S_RD: begin
        fv  = !nak_q;
        fb  = len_q;
        frb = 1'b1;
        fp  = 1'b1;
        if (nak_hit || (fv && fmt_ready_i)) begin
          state_d = S_WAIT;
        end
      end

      S_DRAIN: begin
        txd_ready_c = 1'b1;
        if (rem_q == 8'd0) begin
          state_d = S_WAIT;
        end else if (txd_valid_i) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // The host still looks idle in the entry cycle; skip it.
        if (cnt_q != 16'd0 && host_idle_i) begin
          state_d  = S_RESP;
          status_d = nak_now ? StNak : StOk;
        end else if (cnt_q == TmoLast) begin
          state_d  = S_RESP;
          status_d = nak_now ? StNak : StTimeout;
        end
      end

      S_RESP: begin
        rsp_valid_c = 1'b1;
        if (rsp_ready_i) begin
          nak_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= 7'd0;
      rnw_q    <= 1'b0;
      len_q    <= 8'd0;
      rem_q    <= 8'd0;
      cnt_q    <= 16'd0;
      nak_q    <= 1'b0;
      status_q <= StOk;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rnw_q    <= rnw_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      nak_q    <= nak_d;
      status_q <= status_d;
    end
  end

  logic run;
  logic fv_o;

  assign run           = ~rst_i;
  assign fv_o          = fv & run;
  assign cmd_ready_o   = cmd_ready_c & run;
  assign txd_ready_o   = txd_ready_c & run;
  assign fmt_valid_o   = fv_o;
  assign fmt_byte_o    = fv_o ? fb : 8'h00;
  assign fmt_start_o   = fs & fv_o;
  assign fmt_stop_o    = fp & fv_o;
  assign fmt_readb_o   = frb & fv_o;
  assign fmt_rcont_o   = 1'b0;
  assign fmt_nakok_o   = 1'b0;
  assign nak_pending_o = nak_q & run;
  assign rsp_valid_o   = rsp_valid_c & run;
  assign rsp_status_o  = (rsp_valid_c & run) ? status_q : 2'b00;
  assign busy_o        = (state_q != S_IDLE) & run;

endmodule
